// File: rtl/pattern_gen_vg.sv
// pattern_gen_vg: video test-pattern generator.
// Counts pixels/lines from the incoming timing, selects a pattern once per
// frame (latched on the vsync falling edge) and pushes syncs, data enable
// and colour through a fixed two-register pipeline, so every mode has the
// same latency as plain pass-through.
module pattern_gen_vg #(
   parameter int B         = 8,
   parameter int X_BITS    = 12,
   parameter int Y_BITS    = 12,
   parameter int CELL_LOG2 = 4,
   parameter int GRID_LOG2 = 5
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              vn_in,
   input  logic              hn_in,
   input  logic              dn_in,
   input  logic [B-1:0]      r_in,
   input  logic [B-1:0]      g_in,
   input  logic [B-1:0]      b_in,
   input  logic [2:0]        pattern,
   input  logic [X_BITS-1:0] total_active_pix,
   output logic              vn_out,
   output logic              hn_out,
   output logic              den_out,
   output logic [B-1:0]      r_out,
   output logic [B-1:0]      g_out,
   output logic [B-1:0]      b_out,
   output logic [7:0]        frame_cnt
);

   localparam logic [15:0]       LFSR_SEED = 16'hACE1;
   localparam logic [X_BITS-1:0] X_ONE     = {{(X_BITS-1){1'b0}}, 1'b1};
   localparam logic [Y_BITS-1:0] Y_ONE     = {{(Y_BITS-1){1'b0}}, 1'b1};
   // Width of the moving bar, one bit wider than x so the compare never wraps.
   localparam logic [X_BITS:0]   CELL_SZ   = {{X_BITS{1'b0}}, 1'b1} << CELL_LOG2;

   // Timing edge history and frame-level state
   logic              vn_prev_q, dn_prev_q;
   logic              vn_fall, dn_fall;
   logic [X_BITS-1:0] x_q, x_d;
   logic [Y_BITS-1:0] y_q, y_d;
   logic [2:0]        bar_i_q, bar_i_d;
   logic [X_BITS-1:0] bar_cnt_q, bar_cnt_d;
   logic [X_BITS-1:0] bar_w_q, bar_w_d;
   logic [2:0]        mode_q, mode_d;
   logic [7:0]        frame_q, frame_d;
   logic [15:0]       lfsr_q, lfsr_d;

   // Pipeline stage 1 (pattern applied) and stage 2 (output registers)
   logic              s1_vn_q, s1_hn_q, s1_de_q;
   logic [B-1:0]      s1_r_q, s1_g_q, s1_b_q;
   logic              o_vn_q, o_hn_q, o_de_q;
   logic [B-1:0]      o_r_q, o_g_q, o_b_q;

   // Pattern helpers
   logic              gen_mode;
   logic              checker_on, grid_on, mbar_on;
   logic [X_BITS-1:0] mb_off, mb_diff;
   logic [B-1:0]      ramp_v;
   logic [B-1:0]      pix_r, pix_g, pix_b;

   assign vn_fall = vn_prev_q & ~vn_in;
   assign dn_fall = dn_prev_q & ~dn_in;

   assign checker_on = x_q[CELL_LOG2] ^ y_q[CELL_LOG2];
   assign grid_on    = (x_q[GRID_LOG2-1:0] == '0) || (y_q[GRID_LOG2-1:0] == '0) ||
                       (x_q == (total_active_pix - X_ONE));
   // The bar moves four pixels per frame; subtraction wraps modulo 2^X_BITS.
   assign mb_off     = X_BITS'({frame_q, 2'b00});
   assign mb_diff    = x_q - mb_off;
   assign mbar_on    = ({1'b0, mb_diff} < CELL_SZ);
   // Modes 0 and 7 pass upstream video straight through, blanking included.
   assign gen_mode   = (mode_q != 3'd0) && (mode_q != 3'd7);

   generate
      if (B <= X_BITS) begin : g_ramp_narrow
         assign ramp_v = x_q[B-1:0];
      end else begin : g_ramp_wide
         assign ramp_v = {{(B-X_BITS){1'b0}}, x_q};
      end
   endgenerate

   // Next-state for counters, bar tracking, frame latch and noise LFSR
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      bar_i_d   = bar_i_q;
      bar_cnt_d = bar_cnt_q;
      bar_w_d   = bar_w_q;
      mode_d    = mode_q;
      frame_d   = frame_q;
      // Fibonacci taps 16,14,13,11 in shift-right form
      lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

      if (dn_in) x_d = x_q + X_ONE;
      else       x_d = '0;

      // A vsync edge in the same cycle as end-of-line wins: y restarts at 0.
      if (vn_fall)      y_d = '0;
      else if (dn_fall) y_d = y_q + Y_ONE;

      if (vn_fall) begin
         frame_d = frame_q + 8'd1;
         mode_d  = pattern;
         bar_w_d = total_active_pix >> 3;
      end

      if (!dn_in) begin
         bar_i_d   = 3'd0;
         bar_cnt_d = '0;
      end else if (bar_w_q != '0) begin
         if (bar_cnt_q == (bar_w_q - X_ONE)) begin
            bar_cnt_d = '0;
            if (bar_i_q != 3'd7) bar_i_d = bar_i_q + 3'd1;
         end else begin
            bar_cnt_d = bar_cnt_q + X_ONE;
         end
      end
   end

   // Colour selection for the current input pixel
   always_comb begin
      pix_r = r_in;
      pix_g = g_in;
      pix_b = b_in;
      case (mode_q)
         3'd1: begin
            pix_r = {B{~bar_i_q[1]}};
            pix_g = {B{~bar_i_q[2]}};
            pix_b = {B{~bar_i_q[0]}};
         end
         3'd2: begin
            pix_r = {B{checker_on}};
            pix_g = {B{checker_on}};
            pix_b = {B{checker_on}};
         end
         3'd3: begin
            pix_r = {B{grid_on}};
            pix_g = {B{grid_on}};
            pix_b = {B{grid_on}};
         end
         3'd4: begin
            pix_r = ramp_v;
            pix_g = ramp_v;
            pix_b = ramp_v;
         end
         3'd5: begin
            pix_r = {B{mbar_on}};
            pix_g = {B{mbar_on}};
            pix_b = {B{mbar_on}};
         end
         3'd6: begin
            pix_r = lfsr_q[B-1:0];
            pix_g = lfsr_q[B-1:0];
            pix_b = lfsr_q[B-1:0];
         end
         default: ;
      endcase
      if (gen_mode && !dn_in) begin
         pix_r = '0;
         pix_g = '0;
         pix_b = '0;
      end
   end

   // Frame-level state registers
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         vn_prev_q <= 1'b0;
         dn_prev_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         bar_i_q   <= 3'd0;
         bar_cnt_q <= '0;
         bar_w_q   <= '0;
         mode_q    <= 3'd0;
         frame_q   <= 8'd0;
         lfsr_q    <= LFSR_SEED;
      end else begin
         vn_prev_q <= vn_in;
         dn_prev_q <= dn_in;
         x_q       <= x_d;
         y_q       <= y_d;
         bar_i_q   <= bar_i_d;
         bar_cnt_q <= bar_cnt_d;
         bar_w_q   <= bar_w_d;
         mode_q    <= mode_d;
         frame_q   <= frame_d;
         lfsr_q    <= lfsr_d;
      end
   end

   // Two-stage video pipeline: syncs and colour stay aligned in every mode
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         s1_vn_q <= 1'b0;
         s1_hn_q <= 1'b0;
         s1_de_q <= 1'b0;
         s1_r_q  <= '0;
         s1_g_q  <= '0;
         s1_b_q  <= '0;
         o_vn_q  <= 1'b0;
         o_hn_q  <= 1'b0;
         o_de_q  <= 1'b0;
         o_r_q   <= '0;
         o_g_q   <= '0;
         o_b_q   <= '0;
      end else begin
         s1_vn_q <= vn_in;
         s1_hn_q <= hn_in;
         s1_de_q <= dn_in;
         s1_r_q  <= pix_r;
         s1_g_q  <= pix_g;
         s1_b_q  <= pix_b;
         o_vn_q  <= s1_vn_q;
         o_hn_q  <= s1_hn_q;
         o_de_q  <= s1_de_q;
         o_r_q   <= s1_r_q;
         o_g_q   <= s1_g_q;
         o_b_q   <= s1_b_q;
      end
   end

   assign vn_out    = o_vn_q;
   assign hn_out    = o_hn_q;
   assign den_out   = o_de_q;
   assign r_out     = o_r_q;
   assign g_out     = o_g_q;
   assign b_out     = o_b_q;
   assign frame_cnt = frame_q;

endmodule

// File: tb/tb_pattern_gen_vg.sv
// tb_pattern_gen_vg: directed bench for pattern_gen_vg (default parameters).
module tb_pattern_gen_vg;

   logic        clk_in = 1'b0;
   logic        reset_n;
   logic        vn_in, hn_in, dn_in;
   logic [7:0]  r_in, g_in, b_in;
   logic [2:0]  pattern;
   logic [11:0] total_active_pix;
   logic        vn_out, hn_out, den_out;
   logic [7:0]  r_out, g_out, b_out;
   logic [7:0]  frame_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cap_n;
   logic [7:0]  exp_frames;
   logic [23:0] cap [0:39][0:1023];

   typedef struct {
      logic [2:0]  mode;
      int          npix;
      int          nlines;
      int          y;
      int          x;
      logic [23:0] exp;
   } vec_t;
   vec_t vecs[$];

   pattern_gen_vg dut (
      .clk_in(clk_in), .reset_n(reset_n),
      .vn_in(vn_in), .hn_in(hn_in), .dn_in(dn_in),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .pattern(pattern), .total_active_pix(total_active_pix),
      .vn_out(vn_out), .hn_out(hn_out), .den_out(den_out),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .frame_cnt(frame_cnt)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] pr(input int p);
      return 8'(p) ^ 8'h3C;
   endfunction
   function automatic logic [7:0] pg(input int p);
      return 8'(p + 1);
   endfunction
   function automatic logic [7:0] pb(input int p);
      return ~8'(p);
   endfunction

   function automatic void add_vec(input logic [2:0] m, input int np, input int nl,
                                   input int y, input int x, input logic [23:0] e);
      vec_t v;
      v.mode = m; v.npix = np; v.nlines = nl; v.y = y; v.x = x; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic blank_video();
      dn_in = 1'b0;
      r_in = 8'hC3; g_in = 8'h5A; b_in = 8'h96;
   endtask

   task automatic sample(input int line, input bit chk_blank);
      if (den_out) begin
         if (line < 40 && cap_n < 1024) cap[line][cap_n] = {r_out, g_out, b_out};
         cap_n++;
      end else if (chk_blank) begin
         check("blank_zero", {8'h0, r_out, g_out, b_out}, 32'h0);
      end
   endtask

   task automatic drive_line(input int line, input int npix, input bit chk_blank);
      cap_n = 0;
      blank_video();
      hn_in = 1'b0;
      for (int h = 0; h < 4; h++) begin
         if (h == 2) hn_in = 1'b1;
         tick();
         sample(line, chk_blank);
      end
      for (int p = 0; p < npix + 4; p++) begin
         if (p < npix) begin
            dn_in = 1'b1; r_in = pr(p); g_in = pg(p); b_in = pb(p);
         end else begin
            blank_video();
         end
         tick();
         sample(line, chk_blank);
      end
      check("pix_count", cap_n, npix);
   endtask

   task automatic drive_vsync();
      blank_video();
      hn_in = 1'b1;
      vn_in = 1'b0;
      repeat (3) tick();
      vn_in = 1'b1;
      repeat (3) tick();
      exp_frames = exp_frames + 8'd1;
      check("frame_cnt", frame_cnt, exp_frames);
   endtask

   task automatic drive_frame(input logic [2:0] m, input int npix, input int nlines);
      pattern = m;
      total_active_pix = 12'(npix);
      drive_vsync();
      for (int l = 0; l < nlines; l++)
         drive_line(l, npix, (m != 3'd0) && (m != 3'd7));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      vn_in = 1'b1; hn_in = 1'b1;
      blank_video();
      tick(); tick();
      reset_n = 1'b1;
      exp_frames = 8'd0;
      tick(); tick();
   endtask

   initial begin
      // Vector table: {mode, active pixels, lines, y, x, expected {r,g,b}}
      add_vec(3'd0,  40,  2,  0,   0, 24'h3C01FF);
      add_vec(3'd0,  40,  2,  1,  10, 24'h360BF5);
      add_vec(3'd7,  40,  1,  0,  20, 24'h2815EB);
      add_vec(3'd1, 640,  1,  0,   0, 24'hFFFFFF);
      add_vec(3'd1, 640,  1,  0,  79, 24'hFFFFFF);
      add_vec(3'd1, 640,  1,  0,  80, 24'hFFFF00);
      add_vec(3'd1, 640,  1,  0, 159, 24'hFFFF00);
      add_vec(3'd1, 640,  1,  0, 160, 24'h00FFFF);
      add_vec(3'd1, 640,  1,  0, 240, 24'h00FF00);
      add_vec(3'd1, 640,  1,  0, 320, 24'hFF00FF);
      add_vec(3'd1, 640,  1,  0, 400, 24'hFF0000);
      add_vec(3'd1, 640,  1,  0, 480, 24'h0000FF);
      add_vec(3'd1, 640,  1,  0, 559, 24'h0000FF);
      add_vec(3'd1, 640,  1,  0, 560, 24'h000000);
      add_vec(3'd1, 640,  1,  0, 639, 24'h000000);
      add_vec(3'd2,  40, 18,  0,   0, 24'h000000);
      add_vec(3'd2,  40, 18,  0,  15, 24'h000000);
      add_vec(3'd2,  40, 18,  0,  16, 24'hFFFFFF);
      add_vec(3'd2,  40, 18,  0,  31, 24'hFFFFFF);
      add_vec(3'd2,  40, 18,  0,  32, 24'h000000);
      add_vec(3'd2,  40, 18, 16,   0, 24'hFFFFFF);
      add_vec(3'd2,  40, 18, 16,  16, 24'h000000);
      add_vec(3'd2,  40, 18, 17,  35, 24'hFFFFFF);
      add_vec(3'd3,  40, 34,  1,   0, 24'hFFFFFF);
      add_vec(3'd3,  40, 34,  1,   1, 24'h000000);
      add_vec(3'd3,  40, 34,  1,  32, 24'hFFFFFF);
      add_vec(3'd3,  40, 34,  1,  38, 24'h000000);
      add_vec(3'd3,  40, 34,  1,  39, 24'hFFFFFF);
      add_vec(3'd3,  40, 34,  0,   5, 24'hFFFFFF);
      add_vec(3'd3,  40, 34, 32,   7, 24'hFFFFFF);
      add_vec(3'd3,  40, 34, 33,   7, 24'h000000);
      add_vec(3'd4, 300,  1,  0,   0, 24'h000000);
      add_vec(3'd4, 300,  1,  0,   1, 24'h010101);
      add_vec(3'd4, 300,  1,  0, 255, 24'hFFFFFF);
      add_vec(3'd4, 300,  1,  0, 256, 24'h000000);
      add_vec(3'd4, 300,  1,  0, 299, 24'h2B2B2B);

      // Reset state
      reset_n = 1'b0;
      vn_in = 1'b1; hn_in = 1'b1;
      blank_video();
      pattern = 3'd0;
      total_active_pix = 12'd40;
      exp_frames = 8'd0;
      tick(); tick();
      check("rst_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
      check("rst_syncs", {vn_out, hn_out, den_out}, 3'b000);
      check("rst_frame", frame_cnt, 8'd0);
      reset_n = 1'b1;
      tick(); tick();

      // Table-driven pattern checks, one frame per mode group
      for (int i = 0; i < vecs.size(); i++) begin
         if (i == 0 || vecs[i].mode != vecs[i-1].mode)
            drive_frame(vecs[i].mode, vecs[i].npix, vecs[i].nlines);
         check($sformatf("vec%0d_m%0d_y%0d_x%0d", i, vecs[i].mode, vecs[i].y, vecs[i].x),
               {8'h0, cap[vecs[i].y][vecs[i].x]}, {8'h0, vecs[i].exp});
      end

      // Mode switch 2->4 mid-frame: checker holds until the next vsync
      drive_frame(3'd2, 40, 1);
      pattern = 3'd4;
      drive_line(1, 40, 1);
      check("sw_old_x5", {8'h0, cap[1][5]}, 32'h000000);
      check("sw_old_x16", {8'h0, cap[1][16]}, 32'hFFFFFF);
      drive_vsync();
      drive_line(0, 40, 1);
      check("sw_new_x5", {8'h0, cap[0][5]}, 32'h050505);
      check("sw_new_x16", {8'h0, cap[0][16]}, 32'h101010);

      // Reset asserted mid-line clears outputs without a clock edge
      hn_in = 1'b1;
      for (int p = 0; p < 5; p++) begin
         dn_in = 1'b1; r_in = pr(p); g_in = pg(p); b_in = pb(p);
         tick();
      end
      check("pre_rst_den", den_out, 1'b1);
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
      check("mid_rst_syncs", {vn_out, hn_out, den_out}, 3'b000);
      check("mid_rst_frame", frame_cnt, 8'd0);
      exp_frames = 8'd0;
      blank_video();
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      check("post_rst_syncs", {vn_out, hn_out, den_out}, 3'b110);

      // Latency: single pixel appears exactly two clocks later
      dn_in = 1'b1; r_in = 8'h5A; g_in = 8'h11; b_in = 8'h22;
      tick();
      check("lat_1clk_den", den_out, 1'b0);
      blank_video();
      tick();
      check("lat_2clk_den", den_out, 1'b1);
      check("lat_2clk_rgb", {8'h0, r_out, g_out, b_out}, 32'h5A1122);
      tick();
      check("lat_3clk_den", den_out, 1'b0);
      hn_in = 1'b0;
      tick();
      check("hn_1clk", hn_out, 1'b1);
      hn_in = 1'b1;
      tick();
      check("hn_2clk", hn_out, 1'b0);
      tick();
      check("hn_3clk", hn_out, 1'b1);

      // Pass-through before the first vsync after reset
      drive_line(0, 40, 0);
      for (int p = 0; p < 40; p++)
         check($sformatf("pass_x%0d", p), {8'h0, cap[0][p]}, {8'h0, pr(p), pg(p), pb(p)});

      // Noise: vsync right after reset so the early LFSR states are visible
      reset_n = 1'b0;
      vn_in = 1'b1; hn_in = 1'b1;
      blank_video();
      tick(); tick();
      reset_n = 1'b1;
      exp_frames = 8'd0;
      tick();
      vn_in = 1'b0;
      pattern = 3'd6;
      tick();
      check("noise_frame", frame_cnt, 8'd1);
      exp_frames = 8'd1;
      dn_in = 1'b1;
      tick();
      tick();
      check("noise_p0", {8'h0, r_out, g_out, b_out}, 32'h383838);
      tick();
      check("noise_p1", {8'h0, r_out, g_out, b_out}, 32'h9C9C9C);
      blank_video();
      tick();
      check("noise_p2", {8'h0, r_out, g_out, b_out}, 32'hCECECE);
      tick();
      check("noise_end_den", den_out, 1'b0);
      vn_in = 1'b1;
      tick(); tick();
      drive_line(1, 20, 1);
      for (int p = 0; p < 20; p++)
         check($sformatf("noise_eq_x%0d", p), {cap[1][p][23:16], cap[1][p][23:16]},
               {cap[1][p][15:8], cap[1][p][7:0]});

      // Moving bar at frame_cnt = 3: white on x = 12..27
      do_reset();
      pattern = 3'd5;
      total_active_pix = 12'd40;
      drive_vsync();
      drive_vsync();
      drive_vsync();
      drive_line(0, 40, 1);
      for (int p = 0; p < 40; p++)
         check($sformatf("mbar_x%0d", p), {8'h0, cap[0][p]},
               (p >= 12 && p <= 27) ? 32'hFFFFFF : 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
